// File: rtl/db4_interp.sv
// db4_interp: polyphase 2x interpolator with the db4 synthesis low-pass.
//
// Accepts one signed 9-bit half-rate sample every two clocks and emits one
// filtered full-rate sample per clock, alternating even and odd phase.
// Synthesis taps (x256): g = [-33, 57, 214, 124]
//   even phase: -33*u0 + 214*u1
//   odd  phase:  57*u0 + 124*u1
// The 18-bit accumulator is shifted right by 7 (arithmetic, floor).
//
// Build option:
//   DB4_INTERP_SAT_EN defined     -> clamp the shifted result to [-256, 255]
//   DB4_INTERP_SAT_EN not defined -> keep the low 9 bits (two's-complement wrap)
module db4_interp (
    input  logic              clk,
    input  logic              reset,
    input  logic signed [8:0] x_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic signed [8:0] y_out,
    output logic              y_valid,
    output logic              y_phase,
    output logic              underrun
);

    // IDLE: waiting for a sample; PH0: even output next; PH1: odd output next.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH0  = 2'd1,
        PH1  = 2'd2
    } state_t;

    // Synthesis coefficients, already scaled by 256.
    localparam logic signed [17:0] C_EVEN_U0 = -18'sd33;
    localparam logic signed [17:0] C_EVEN_U1 =  18'sd214;
    localparam logic signed [17:0] C_ODD_U0  =  18'sd57;
    localparam logic signed [17:0] C_ODD_U1  =  18'sd124;

    state_t            state;
    state_t            state_nxt;
    logic              accept;     // capture x_in into the delay line this edge
    logic              emit;       // register a new output sample this edge
    logic              stall;      // PH1 edge without a follow-on sample

    logic signed [8:0]  u0;        // newest accepted sample
    logic signed [8:0]  u1;        // previous accepted sample
    logic signed [17:0] acc_even;
    logic signed [17:0] acc_odd;
    logic signed [17:0] acc_sel;
    logic signed [17:0] acc_shr;
    logic signed [8:0]  y_nxt;

    // Ready whenever the next edge is not the even-output edge.
    assign in_ready = (state != PH0);

    // Track the output phase; advance on every PH edge, restart on accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking (<=) so every register
            // samples pre-edge values, independent of statement order.
            state <= state_nxt;
        end
    end

    // Next-state and per-edge control strobes derived from state and in_valid.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // left one unassigned would infer a latch.
        state_nxt = state;
        accept    = 1'b0;
        emit      = 1'b0;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = PH0;
                end
            end
            PH0: begin
                // in_valid is ignored here; upstream holds its sample.
                emit      = 1'b1;
                state_nxt = PH1;
            end
            PH1: begin
                emit = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = PH0;
                end else begin
                    stall     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Full-precision products; worst case |acc| < 2^16, so 18 bits never overflow.
    assign acc_even = C_EVEN_U0 * u0 + C_EVEN_U1 * u1;
    assign acc_odd  = C_ODD_U0  * u0 + C_ODD_U1  * u1;

    // Select the active phase's accumulator and reduce it to the 9-bit output.
    always_comb begin
        acc_sel = (state == PH1) ? acc_odd : acc_even;
        acc_shr = acc_sel >>> 7;
`ifdef DB4_INTERP_SAT_EN
        if (acc_shr > 18'sd255) begin
            y_nxt = 9'sd255;
        end else if (acc_shr < -18'sd256) begin
            y_nxt = 9'sh100;                 // -256
        end else begin
            y_nxt = 9'(acc_shr);
        end
`else
        y_nxt = 9'(acc_shr);
`endif
    end

    // Delay line and output register; the delay line survives IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the delay line is cleared by reset because the first
            // post-reset output must see u1 = 0, not a stale sample.
            u0       <= '0;
            u1       <= '0;
            y_out    <= '0;
            y_valid  <= 1'b0;
            y_phase  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (accept) begin
                u1 <= u0;
                u0 <= x_in;
            end
            y_valid  <= emit;
            underrun <= stall;
            if (emit) begin
                y_out   <= y_nxt;
                y_phase <= (state == PH1);
            end
        end
    end

endmodule

// File: tb/tb_db4_interp.sv
// Self-checking bench for db4_interp. A reference model records every
// accepted sample with the edge number it was taken on and derives the
// expected outputs from the filter equations with integer arithmetic.
// Honours DB4_INTERP_SAT_EN the same way the design does.
module tb_db4_interp;

    logic              clk = 1'b0;
    logic              reset;
    logic signed [8:0] x_in;
    logic              in_valid;
    logic              in_ready;
    logic signed [8:0] y_out;
    logic              y_valid;
    logic              y_phase;
    logic              underrun;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int edge_n = 0;      // rising edges counted since start
    int acc_edges[$];    // edge numbers on which a sample was accepted
    int acc_vals[$];     // the accepted sample values (same index)
    int exp_y  = 0;      // expected y_out (holds between outputs)

    db4_interp dut (
        .clk      (clk),
        .reset    (reset),
        .x_in     (x_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y_out    (y_out),
        .y_valid  (y_valid),
        .y_phase  (y_phase),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    // Filter output for newest sample a, previous sample b.
    function automatic int ref_result(input int a, input int b, input bit odd);
        int acc;
        int q;
        acc = odd ? (57 * a + 124 * b) : (-33 * a + 214 * b);
        q   = acc >>> 7;
`ifdef DB4_INTERP_SAT_EN
        if (q > 255)       q = 255;
        else if (q < -256) q = -256;
`else
        q = q & 511;
        if (q >= 256) q = q - 512;
`endif
        return q;
    endfunction

    // Index of the accept that happened on edge e, or -1.
    function automatic int find_acc(input int e);
        for (int i = acc_edges.size() - 1; i >= 0 && i >= acc_edges.size() - 2; i--)
            if (acc_edges[i] == e) return i;
        return -1;
    endfunction

    function automatic int prev_val(input int i);
        return (i > 0) ? acc_vals[i - 1] : 0;
    endfunction

    task automatic model_clear();
        acc_edges.delete();
        acc_vals.delete();
        exp_y = 0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        x_in     = '0;
        reset    = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
    endtask

    // Drive one cycle and compare every output with the model.
    task automatic step(input bit v, input logic signed [8:0] d);
        bit                exp_ready;
        bit                acc_now;
        bit                exp_valid;
        bit                exp_ur;
        bit                exp_ph;
        int                i_e;
        int                i_o;
        logic signed [8:0] e9;
        x_in     = d;
        in_valid = v;
        #1;
        exp_ready = (find_acc(edge_n) < 0);
        checks++;
        if (in_ready !== exp_ready) begin
            errors++;
            $display("FAIL in_ready @edge %0d: got %b want %b", edge_n, in_ready, exp_ready);
        end
        acc_now = v && exp_ready;
        @(posedge clk); #1;
        edge_n++;
        if (acc_now) begin
            acc_edges.push_back(edge_n);
            acc_vals.push_back(int'(d));
        end
        i_e       = find_acc(edge_n - 1);
        i_o       = find_acc(edge_n - 2);
        exp_valid = (i_e >= 0) || (i_o >= 0);
        exp_ph    = 1'b0;
        if (i_e >= 0) begin
            exp_y = ref_result(acc_vals[i_e], prev_val(i_e), 1'b0);
        end else if (i_o >= 0) begin
            exp_y  = ref_result(acc_vals[i_o], prev_val(i_o), 1'b1);
            exp_ph = 1'b1;
        end
        exp_ur = (i_o >= 0) && !acc_now;
        e9     = exp_y[8:0];
        checks++;
        if (y_valid !== exp_valid) begin
            errors++;
            $display("FAIL y_valid @edge %0d: got %b want %b", edge_n, y_valid, exp_valid);
        end
        checks++;
        if (y_out !== e9) begin
            errors++;
            $display("FAIL y_out @edge %0d: got %0d want %0d", edge_n, y_out, e9);
        end
        if (exp_valid) begin
            checks++;
            if (y_phase !== exp_ph) begin
                errors++;
                $display("FAIL y_phase @edge %0d: got %b want %b", edge_n, y_phase, exp_ph);
            end
        end
        checks++;
        if (underrun !== exp_ur) begin
            errors++;
            $display("FAIL underrun @edge %0d: got %b want %b", edge_n, underrun, exp_ur);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        x_in     = '0;
        #2;
        checks++;
        if ({y_out, y_valid, y_phase, underrun, in_ready} !== {9'sd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values: got y=%0d v=%b ph=%b ur=%b rdy=%b want 0 0 0 0 1",
                     y_out, y_valid, y_phase, underrun, in_ready);
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        checks++;
        if (in_ready !== 1'b1 || y_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got rdy=%b v=%b want 1 0", in_ready, y_valid);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 9'sd50);
        step(1'b0, 9'sd0);      // even output now valid, odd still pending
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({y_out, y_valid, y_phase, underrun, in_ready} !== {9'sd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_values: got y=%0d v=%b ph=%b ur=%b rdy=%b want 0 0 0 0 1",
                     y_out, y_valid, y_phase, underrun, in_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        checks++;
        if (in_ready !== 1'b1 || y_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release: got rdy=%b v=%b want 1 0", in_ready, y_valid);
        end
        step(1'b1, 9'sd80);
        step(1'b0, 9'sd0);
        // -33*80 + 214*0 = -2640 ; floor(-2640/128) = -21
        checks++;
        if (y_out !== -9'sd21) begin
            errors++;
            $display("FAIL reset_first_out: got %0d want -21", y_out);
        end
        step(1'b0, 9'sd0);
        step(1'b0, 9'sd0);
    endtask

    task automatic test_impulse();
        int                want_y[6]  = '{-26, 44, 167, 96, 0, 0};
        bit                want_ph[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic signed [8:0] got_y[6];
        bit                got_ph[6];
        logic signed [8:0] w9;
        do_reset();
        step(1'b1, 9'sd100);
        step(1'b0, 9'sd0);   got_y[0] = y_out; got_ph[0] = y_phase;
        step(1'b1, 9'sd0);   got_y[1] = y_out; got_ph[1] = y_phase;
        step(1'b0, 9'sd0);   got_y[2] = y_out; got_ph[2] = y_phase;
        step(1'b0, 9'sd0);   got_y[3] = y_out; got_ph[3] = y_phase;
        step(1'b1, 9'sd0);
        step(1'b0, 9'sd0);   got_y[4] = y_out; got_ph[4] = y_phase;
        step(1'b0, 9'sd0);   got_y[5] = y_out; got_ph[5] = y_phase;
        for (int k = 0; k < 6; k++) begin
            w9 = want_y[k][8:0];
            checks++;
            if (got_y[k] !== w9 || got_ph[k] !== want_ph[k]) begin
                errors++;
                $display("FAIL impulse[%0d]: got y=%0d ph=%b want y=%0d ph=%b",
                         k, got_y[k], got_ph[k], w9, want_ph[k]);
            end
        end
    endtask

    task automatic test_dc(input logic signed [8:0] level, input int sat_val, input int wrap_val);
        logic signed [8:0] w9;
        int                w;
`ifdef DB4_INTERP_SAT_EN
        w = sat_val;
`else
        w = wrap_val;
`endif
        w9 = w[8:0];
        do_reset();
        repeat (20) step(1'b1, level);
        for (int k = 0; k < 6; k++) begin
            step(1'b1, level);
            checks++;
            if (y_out !== w9 || y_valid !== 1'b1) begin
                errors++;
                $display("FAIL dc_%0d[%0d]: got y=%0d v=%b want y=%0d v=1", level, k, y_out, y_valid, w9);
            end
        end
        repeat (3) step(1'b0, 9'sd0);
    endtask

    task automatic test_stall();
        step(1'b1, 9'sd37);
        step(1'b0, 9'sd0);
        step(1'b0, 9'sd0);      // odd output, stream goes idle
        checks++;
        if (underrun !== 1'b1 || y_valid !== 1'b1 || y_phase !== 1'b1) begin
            errors++;
            $display("FAIL stall_edge: got ur=%b v=%b ph=%b want 1 1 1", underrun, y_valid, y_phase);
        end
        step(1'b0, 9'sd0);
        checks++;
        if (underrun !== 1'b0 || y_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_idle: got ur=%b v=%b rdy=%b want 0 0 1", underrun, y_valid, in_ready);
        end
        repeat (3) step(1'b0, 9'sd0);
        step(1'b1, -9'sd90);
        step(1'b0, 9'sd0);
        // -33*(-90) + 214*37 = 10888 ; floor(10888/128) = 85
        checks++;
        if (y_out !== 9'sd85) begin
            errors++;
            $display("FAIL stall_resume: got %0d want 85", y_out);
        end
        step(1'b0, 9'sd0);
    endtask

    task automatic test_backpressure();
        int ready_cnt = 0;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            if (in_ready === 1'b1) ready_cnt++;
            step(1'b1, 9'($urandom_range(0, 511)));
        end
        checks++;
        if (ready_cnt !== 20) begin
            errors++;
            $display("FAIL backpressure_accepts: got %0d want 20", ready_cnt);
        end
        repeat (3) step(1'b0, 9'sd0);
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++)
            step($urandom_range(0, 3) != 0, 9'($urandom_range(0, 511)));
        repeat (3) step(1'b0, 9'sd0);
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_impulse();
        test_dc(9'sd200, 255, -230);
        test_dc(9'sh100, -256, 150);
        test_stall();
        test_backpressure();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
